// File: rtl/stage2_butterfly_rounded_pkg.sv
// Shared constants for the stage-2 radix-2 DIF butterfly block: Q15 twiddles and scale shift.
package stage2_butterfly_rounded_pkg;

    // Twiddle coefficients are 17-bit signed so that +32768 (1.0 in Q15) is exact.
    localparam int unsigned TW_W      = 17;
    localparam int unsigned Q15_SHIFT = 15;

    // W[k] = exp(-j*2*pi*k/8) in Q15, rounded to nearest.
    localparam logic signed [TW_W-1:0] WR [4] = '{
        17'sd32768, 17'sd23170, 17'sd0, -17'sd23170
    };
    localparam logic signed [TW_W-1:0] WI [4] = '{
        17'sd0, -17'sd23170, -17'sd32768, -17'sd23170
    };

endpackage

// File: rtl/stage2_butterfly_rounded_bf2_cplx_unit.sv
// Single radix-2 DIF butterfly: top = (a+c) scaled to Q15, bottom = (a-c) * W[K]. Purely combinational.
module bf2_cplx_unit
    import stage2_butterfly_rounded_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 48,
    parameter int K    = 0
) (
    input  logic signed [INW-1:0]  i_ar,
    input  logic signed [INW-1:0]  i_ai,
    input  logic signed [INW-1:0]  i_cr,
    input  logic signed [INW-1:0]  i_ci,
    output logic signed [OUTW-1:0] o_sr,
    output logic signed [OUTW-1:0] o_si,
    output logic signed [OUTW-1:0] o_dr,
    output logic signed [OUTW-1:0] o_di
);

    // One extra bit keeps the sum/difference exact.
    logic signed [INW:0]      w_sum_r;
    logic signed [INW:0]      w_sum_i;
    logic signed [INW:0]      w_dif_r;
    logic signed [INW:0]      w_dif_i;
    logic signed [OUTW-1:0]   w_dr_x;
    logic signed [OUTW-1:0]   w_di_x;
    logic signed [OUTW-1:0]   w_wr_x;
    logic signed [OUTW-1:0]   w_wi_x;

    assign w_sum_r = (INW+1)'(i_ar) + (INW+1)'(i_cr);
    assign w_sum_i = (INW+1)'(i_ai) + (INW+1)'(i_ci);
    assign w_dif_r = (INW+1)'(i_ar) - (INW+1)'(i_cr);
    assign w_dif_i = (INW+1)'(i_ai) - (INW+1)'(i_ci);

    // Everything is widened to OUTW before multiplying, so no product is truncated.
    assign w_dr_x = OUTW'(w_dif_r);
    assign w_di_x = OUTW'(w_dif_i);
    assign w_wr_x = OUTW'(WR[K]);
    assign w_wi_x = OUTW'(WI[K]);

    // Top output shares the Q15 format of the twiddled bottom output.
    assign o_sr = OUTW'(w_sum_r) <<< Q15_SHIFT;
    assign o_si = OUTW'(w_sum_i) <<< Q15_SHIFT;
    assign o_dr = (w_dr_x * w_wr_x) - (w_di_x * w_wi_x);
    assign o_di = (w_dr_x * w_wi_x) + (w_di_x * w_wr_x);

endmodule

// File: rtl/stage2_butterfly_rounded.sv
// Stage 2 of a 16-point radix-2 DIF FFT: two independent 8-point halves, one registered clock.
module stage2_butterfly_rounded
    import stage2_butterfly_rounded_pkg::*;
#(
    parameter int INW  = 16,
    parameter int OUTW = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [16*INW-1:0]    xr_in_flat,
    input  logic [16*INW-1:0]    xi_in_flat,
    output logic                 out_valid,
    output logic [16*OUTW-1:0]   yr_out_flat,
    output logic [16*OUTW-1:0]   yi_out_flat
);

    logic [16*OUTW-1:0] w_yr;
    logic [16*OUTW-1:0] w_yi;
    logic               r_out_valid;
    logic [16*OUTW-1:0] r_yr;
    logic [16*OUTW-1:0] r_yi;

    // Butterfly g pairs x[b+k] with x[b+k+4], base b = 0 or 8, twiddle index k = g % 4.
    for (genvar g = 0; g < 8; g++) begin : g_bf
        localparam int B  = (g / 4) * 8;
        localparam int KK = g % 4;
        localparam int LO = B + KK;
        localparam int HI = B + KK + 4;

        bf2_cplx_unit #(
            .INW  (INW),
            .OUTW (OUTW),
            .K    (KK)
        ) u_bf (
            .i_ar (xr_in_flat[LO*INW +: INW]),
            .i_ai (xi_in_flat[LO*INW +: INW]),
            .i_cr (xr_in_flat[HI*INW +: INW]),
            .i_ci (xi_in_flat[HI*INW +: INW]),
            .o_sr (w_yr[LO*OUTW +: OUTW]),
            .o_si (w_yi[LO*OUTW +: OUTW]),
            .o_dr (w_yr[HI*OUTW +: OUTW]),
            .o_di (w_yi[HI*OUTW +: OUTW])
        );
    end

    // Output register: reset clears, valid input loads, otherwise data holds and valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_yr        <= '0;
            r_yi        <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_yr <= w_yr;
                r_yi <= w_yi;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign yr_out_flat = r_yr;
    assign yi_out_flat = r_yi;

endmodule

// File: tb/tb_stage2_butterfly_rounded.sv
// Self-checking bench for stage2_butterfly_rounded: directed vectors plus random traffic vs a model.
module tb_stage2_butterfly_rounded;

    localparam int INW  = 16;
    localparam int OUTW = 48;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [16*INW-1:0]   xr_in_flat = '0;
    logic [16*INW-1:0]   xi_in_flat = '0;
    logic                out_valid;
    logic [16*OUTW-1:0]  yr_out_flat;
    logic [16*OUTW-1:0]  yi_out_flat;

    int     n_tests = 0;
    int     n_fail  = 0;

    int     vr [16];
    int     vi [16];
    longint er [16];
    longint ei [16];
    longint ev = 0;

    longint twr [4] = '{32768, 23170, 0, -23170};
    longint twi [4] = '{0, -23170, -32768, -23170};

    stage2_butterfly_rounded #(
        .INW  (INW),
        .OUTW (OUTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .xr_in_flat  (xr_in_flat),
        .xi_in_flat  (xi_in_flat),
        .out_valid   (out_valid),
        .yr_out_flat (yr_out_flat),
        .yi_out_flat (yi_out_flat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint yr_s(input int i);
        logic signed [OUTW-1:0] v;
        v = yr_out_flat[i*OUTW +: OUTW];
        return longint'(v);
    endfunction

    function automatic longint yi_s(input int i);
        logic signed [OUTW-1:0] v;
        v = yi_out_flat[i*OUTW +: OUTW];
        return longint'(v);
    endfunction

    // Reference: y[b+k] = (a+c)*2^15, y[b+k+4] = (a-c)*W[k], plain complex arithmetic.
    task automatic model();
        longint ar, ai, cr, ci, dr, di;
        for (int b = 0; b < 16; b += 8) begin
            for (int k = 0; k < 4; k++) begin
                ar = vr[b+k];   ai = vi[b+k];
                cr = vr[b+k+4]; ci = vi[b+k+4];
                er[b+k] = (ar + cr) * 32768;
                ei[b+k] = (ai + ci) * 32768;
                dr = ar - cr;
                di = ai - ci;
                er[b+k+4] = dr * twr[k] - di * twi[k];
                ei[b+k+4] = dr * twi[k] + di * twr[k];
            end
        end
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 16; i++) begin
            vr[i] = int'($urandom_range(0, 65535)) - 32768;
            vi[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic zero_vec();
        for (int i = 0; i < 16; i++) begin
            vr[i] = 0;
            vi[i] = 0;
        end
    endtask

    // Drive one cycle, update the expected outputs, then compare everything just after the edge.
    task automatic apply(input bit v, input bit rn);
        @(negedge clk);
        rst_n    = rn;
        in_valid = v;
        for (int i = 0; i < 16; i++) begin
            xr_in_flat[i*INW +: INW] = 16'(vr[i]);
            xi_in_flat[i*INW +: INW] = 16'(vi[i]);
        end
        @(posedge clk);
        #1;
        if (!rn) begin
            ev = 0;
            for (int i = 0; i < 16; i++) begin
                er[i] = 0;
                ei[i] = 0;
            end
        end else if (v) begin
            model();
            ev = 1;
        end else begin
            ev = 0;
        end
        check("out_valid", longint'(out_valid), ev);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("yr[%0d]", i), yr_s(i), er[i]);
            check($sformatf("yi[%0d]", i), yi_s(i), ei[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            er[i] = 0;
            ei[i] = 0;
        end

        // Reset, with a vector present that must be discarded.
        rand_vec();
        apply(1'b1, 1'b0);
        apply(1'b0, 1'b0);
        apply(1'b0, 1'b1);

        // Mixed-sign reference vector.
        vr = '{24, -8, -8, -8, 28, -8, -8, -8, 32, -8, -8, -8, 36, -8, -8, -8};
        vi = '{0, 8, 0, -8, 0, 8, 0, -8, 0, 8, 0, -8, 0, 8, 0, -8};
        apply(1'b1, 1'b1);
        check("ref_y0r", yr_s(0), 64'sd52 * 32768);
        check("ref_y1i", yi_s(1), 64'sd16 * 32768);
        check("ref_y4r", yr_s(4), -64'sd4 * 32768);
        check("ref_y5r", yr_s(5), 64'sd0);
        check("ref_y8r", yr_s(8), 64'sd68 * 32768);

        // Unit impulses exercise each nontrivial twiddle.
        zero_vec(); vr[1] = 1;
        apply(1'b1, 1'b1);
        check("imp1_y1r", yr_s(1), 64'sd32768);
        check("imp1_y5r", yr_s(5), 64'sd23170);
        check("imp1_y5i", yi_s(5), -64'sd23170);
        zero_vec(); vr[2] = 1;
        apply(1'b1, 1'b1);
        check("imp2_y6r", yr_s(6), 64'sd0);
        check("imp2_y6i", yi_s(6), -64'sd32768);
        zero_vec(); vr[3] = 1;
        apply(1'b1, 1'b1);
        check("imp3_y7r", yr_s(7), -64'sd23170);
        check("imp3_y7i", yi_s(7), -64'sd23170);

        // Full-scale extremes must not overflow.
        zero_vec(); vr[0] = 32767; vr[4] = -32768;
        apply(1'b1, 1'b1);
        check("ext_y0r", yr_s(0), -64'sd32768);
        check("ext_y4r", yr_s(4), 64'sd2147450880);

        // Hold when in_valid drops.
        rand_vec();
        apply(1'b0, 1'b1);

        // Random back-to-back traffic with in_valid toggling.
        for (int n = 0; n < 200; n++) begin
            rand_vec();
            apply(1'($urandom_range(0, 3) != 0), 1'b1);
        end

        // Reset mid-stream with in_valid high, then recovery.
        rand_vec();
        apply(1'b1, 1'b1);
        rand_vec();
        apply(1'b1, 1'b0);
        rand_vec();
        apply(1'b0, 1'b1);
        rand_vec();
        apply(1'b1, 1'b1);
        for (int n = 0; n < 20; n++) begin
            rand_vec();
            apply(1'($urandom_range(0, 1)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage2_butterfly_rounded.md
STAGE2_BUTTERFLY_ROUNDED -- requirements
Module: stage2_butterfly_rounded

Interface
REQ-001 Parameter INW, default 16: signed two's-complement width of each real/imag input sample.
REQ-002 Parameter OUTW, default 48: signed width of each real/imag output sample; OUTW SHALL be >= INW+18.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  xr_in_flat/xi_in_flat hold a valid 16-point vector this cycle.
REQ-006 xr_in_flat  input  16*INW  real parts; sample i at bits [i*INW +: INW], signed.
REQ-007 xi_in_flat  input  16*INW  imaginary parts, same packing as xr_in_flat.
REQ-008 out_valid  output  1  yr_out_flat/yi_out_flat hold a new result.
REQ-009 yr_out_flat  output  16*OUTW  real results; sample i at [i*OUTW +: OUTW], signed, Q15-scaled (value x 32768).
REQ-010 yi_out_flat  output  16*OUTW  imaginary results, same packing.

Function
REQ-011 The block SHALL be stage 2 of a 16-point radix-2 DIF FFT: two independent 8-point halves, base b in {0,8}.
REQ-012 For each b and k = 0..3, with a = x[b+k] and c = x[b+k+4]: y[b+k] = (a+c) x 32768 and y[b+k+4] = (a-c) x W[k].
REQ-013 Twiddles W[k] = exp(-j*2*pi*k/8) in Q15, rounded to nearest: W0 = 32768+0j, W1 = 23170-23170j, W2 = 0-32768j, W3 = -23170-23170j.
REQ-014 Twiddle coefficients SHALL be 17-bit signed so that +32768 is exact.
REQ-015 Complex multiply: yr = dr*wr - di*wi, yi = dr*wi + di*wr, where dr,di are the INW+1-bit sum/difference parts.
REQ-016 All arithmetic SHALL be full precision: sign-extend to OUTW, no truncation, no rounding of products, no saturation.
REQ-017 Top outputs SHALL be scaled by exactly 32768 (left shift 15) so all 16 outputs share the Q15 format.
REQ-018 Latency SHALL be one clock: inputs sampled on a rising edge with in_valid=1 appear on the outputs after that edge, with out_valid=1.
REQ-019 When in_valid=0 at a rising edge, out_valid SHALL become 0 and the data outputs SHALL hold their previous values.
REQ-020 Back-to-back in_valid SHALL be accepted every cycle (throughput one vector per clock, no stall).

Reset
REQ-021 While rst_n=0 at a rising edge, out_valid, yr_out_flat and yi_out_flat SHALL be cleared to 0; reset has priority over in_valid.
REQ-022 A vector presented in the same cycle as reset SHALL be discarded; the first valid output follows the first in_valid edge after rst_n returns to 1.

Structure
REQ-023 A shared package SHALL hold the four Q15 twiddle constants (WR[k], WI[k], 17-bit) and the Q15 shift constant 15.
REQ-024 One sub-module, bf2_cplx_unit, SHALL implement a single radix-2 butterfly (sum scaled by 32768, difference times twiddle), instantiated 8 times; the output register lives in the top.

Verification
REQ-025 Vector x = [24, -8+8j, -8, -8-8j, 28, -8+8j, -8, -8-8j, 32, -8+8j, -8, -8-8j, 36, -8+8j, -8, -8-8j] -> y/32768 = [52, -16+16j, -16, -16-16j, -4, 0, 0, 0, 68, -16+16j, -16, -16-16j, -4, 0, 0, 0].
REQ-026 Unit impulses x1 = 1, x2 = 1, x3 = 1 (one per cycle) -> y5 = 23170-23170j, then y6 = 0-32768j, then y7 = -23170-23170j; y1, y2, y3 = 32768 respectively.
REQ-027 Extremes: x0 = 32767, x4 = -32768 -> y0 = -32768, y4 = 2147450880, with no overflow.
REQ-028 Assert rst_n=0 mid-stream with in_valid=1 -> all outputs 0 and out_valid=0 next edge; the first valid result follows the first in_valid edge after release.
REQ-029 Random back-to-back vectors with in_valid toggling -> each output matches the golden model one cycle later; outputs hold when in_valid=0.
